// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grant with one-cycle cool-down on the
// unit just granted, then a registered broadcast of that unit's result.
module cdb_arbiter #(
  parameter int unsigned NUM_UNITS  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 6
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_UNITS-1:0]            CDB_rts,
  input  logic [NUM_UNITS-1:0]            CDB_write,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] CDB_data_in,
  input  logic [NUM_UNITS*TAG_WIDTH-1:0]  CDB_source_in,
  output logic [NUM_UNITS-1:0]            CDB_xmit,
  output logic [DATA_WIDTH-1:0]           bus_data,
  output logic [TAG_WIDTH-1:0]            bus_source,
  output logic                            bus_valid,
  output logic                            busy,
  output logic                            error
);

  localparam int unsigned PtrW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS-1:0]  xmit_q, xmit_d;
  logic [NUM_UNITS-1:0]  eligible;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [PtrW-1:0]       idx;
  logic                  found;
  logic [DATA_WIDTH-1:0] bus_data_q, bus_data_d;
  logic [TAG_WIDTH-1:0]  bus_source_q, bus_source_d;
  logic                  bus_valid_q, bus_valid_d;
  logic                  error_q, error_d;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [TAG_WIDTH-1:0]  cap_source;
  logic                  cap_write;

  // The current grant holder still has rts high at its retiring edge.
  assign eligible = CDB_rts & ~xmit_q;

  always_comb begin
    xmit_d = '0;
    ptr_d  = ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned off = 0; off < NUM_UNITS; off++) begin
      idx = PtrW'((32'(ptr_q) + off) % NUM_UNITS);
      if (!found && eligible[idx]) begin
        found       = 1'b1;
        xmit_d[idx] = 1'b1;
        ptr_d       = PtrW'((32'(idx) + 32'd1) % NUM_UNITS);
      end
    end
  end

  always_comb begin
    cap_data   = '0;
    cap_source = '0;
    cap_write  = 1'b0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (xmit_q[i]) begin
        cap_data   = CDB_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        cap_source = CDB_source_in[i*TAG_WIDTH +: TAG_WIDTH];
        cap_write  = CDB_write[i];
      end
    end
  end

  always_comb begin
    bus_data_d   = bus_data_q;
    bus_source_d = bus_source_q;
    bus_valid_d  = 1'b0;
    error_d      = error_q;
    if (|xmit_q) begin
      bus_data_d   = cap_data;
      bus_source_d = cap_source;
      bus_valid_d  = cap_write;
      error_d      = error_q | ~cap_write;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xmit_q       <= '0;
      ptr_q        <= '0;
      bus_data_q   <= '0;
      bus_source_q <= '0;
      bus_valid_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      xmit_q       <= xmit_d;
      ptr_q        <= ptr_d;
      bus_data_q   <= bus_data_d;
      bus_source_q <= bus_source_d;
      bus_valid_q  <= bus_valid_d;
      error_q      <= error_d;
    end
  end

  assign CDB_xmit   = xmit_q;
  assign bus_data   = bus_data_q;
  assign bus_source = bus_source_q;
  assign bus_valid  = bus_valid_q;
  assign busy       = |xmit_q;
  assign error      = error_q;

endmodule
